// File: rtl/crossbar_8x8_rdata_return.sv
// Read-data return path of the 8x8 LSU<->bank-group crossbar: re-derives each bank group's grant,
// carries it through an RD_LAT-deep tag pipe and steers bank data back to the requesting LSU.
module crossbar_8x8_rdata_return #(
    parameter int A_W    = 16,
    parameter int D_W    = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       LSU_req_vld,
    input  logic [A_W+2:0]   LSU_addr_bus_0,
    input  logic [A_W+2:0]   LSU_addr_bus_1,
    input  logic [A_W+2:0]   LSU_addr_bus_2,
    input  logic [A_W+2:0]   LSU_addr_bus_3,
    input  logic [A_W+2:0]   LSU_addr_bus_4,
    input  logic [A_W+2:0]   LSU_addr_bus_5,
    input  logic [A_W+2:0]   LSU_addr_bus_6,
    input  logic [A_W+2:0]   LSU_addr_bus_7,
    input  logic [D_W-1:0]   BG_data_out_0,
    input  logic [D_W-1:0]   BG_data_out_1,
    input  logic [D_W-1:0]   BG_data_out_2,
    input  logic [D_W-1:0]   BG_data_out_3,
    input  logic [D_W-1:0]   BG_data_out_4,
    input  logic [D_W-1:0]   BG_data_out_5,
    input  logic [D_W-1:0]   BG_data_out_6,
    input  logic [D_W-1:0]   BG_data_out_7,
    output logic [D_W-1:0]   LSU_rdata_0,
    output logic [D_W-1:0]   LSU_rdata_1,
    output logic [D_W-1:0]   LSU_rdata_2,
    output logic [D_W-1:0]   LSU_rdata_3,
    output logic [D_W-1:0]   LSU_rdata_4,
    output logic [D_W-1:0]   LSU_rdata_5,
    output logic [D_W-1:0]   LSU_rdata_6,
    output logic [D_W-1:0]   LSU_rdata_7,
    output logic [7:0]       LSU_rdata_vld,
    output logic [7:0]       LSU_conflict
);

    logic [2:0]     sel [8];
    logic [D_W-1:0] bg_data [8];
    logic [7:0]     win_hit;
    logic [2:0]     win_idx [8];
    logic [3:0]     tag [8][RD_LAT];
    logic [7:0]     vld_nxt;
    logic [D_W-1:0] data_nxt [8];
    logic [D_W-1:0] rdata_q [8];
    logic           unused_addr;

    assign sel[0] = LSU_addr_bus_0[A_W+2:A_W];
    assign sel[1] = LSU_addr_bus_1[A_W+2:A_W];
    assign sel[2] = LSU_addr_bus_2[A_W+2:A_W];
    assign sel[3] = LSU_addr_bus_3[A_W+2:A_W];
    assign sel[4] = LSU_addr_bus_4[A_W+2:A_W];
    assign sel[5] = LSU_addr_bus_5[A_W+2:A_W];
    assign sel[6] = LSU_addr_bus_6[A_W+2:A_W];
    assign sel[7] = LSU_addr_bus_7[A_W+2:A_W];

    // Address bits belong to the address crossbar; only the bank select matters on the return side.
    assign unused_addr = ^{LSU_addr_bus_0[A_W-1:0], LSU_addr_bus_1[A_W-1:0],
                           LSU_addr_bus_2[A_W-1:0], LSU_addr_bus_3[A_W-1:0],
                           LSU_addr_bus_4[A_W-1:0], LSU_addr_bus_5[A_W-1:0],
                           LSU_addr_bus_6[A_W-1:0], LSU_addr_bus_7[A_W-1:0]};

    assign bg_data[0] = BG_data_out_0;
    assign bg_data[1] = BG_data_out_1;
    assign bg_data[2] = BG_data_out_2;
    assign bg_data[3] = BG_data_out_3;
    assign bg_data[4] = BG_data_out_4;
    assign bg_data[5] = BG_data_out_5;
    assign bg_data[6] = BG_data_out_6;
    assign bg_data[7] = BG_data_out_7;

    // Ascending scan so the last match, i.e. the highest LSU index, wins, matching the address crossbar.
    always_comb begin
        for (int b = 0; b < 8; b++) begin
            win_hit[b] = 1'b0;
            win_idx[b] = 3'd0;
            for (int i = 0; i < 8; i++) begin
                if (LSU_req_vld[i] && (sel[i] == 3'(b))) begin
                    win_hit[b] = 1'b1;
                    win_idx[b] = 3'(i);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            LSU_conflict[i] = LSU_req_vld[i] && (win_idx[sel[i]] != 3'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 8; b++) begin
                for (int s = 0; s < RD_LAT; s++) begin
                    tag[b][s] <= 4'd0;
                end
            end
        end else begin
            for (int b = 0; b < 8; b++) begin
                tag[b][0] <= {win_hit[b], win_idx[b]};
                for (int s = 1; s < RD_LAT; s++) begin
                    tag[b][s] <= tag[b][s-1];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            vld_nxt[i]  = 1'b0;
            data_nxt[i] = '0;
            for (int b = 0; b < 8; b++) begin
                if (tag[b][RD_LAT-1][3] && (tag[b][RD_LAT-1][2:0] == 3'(i))) begin
                    vld_nxt[i]  = 1'b1;
                    data_nxt[i] = bg_data[b];
                end
            end
        end
    end

    // Data is zeroed rather than held when nothing returns, so idle lanes read as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LSU_rdata_vld <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            LSU_rdata_vld <= vld_nxt;
            for (int i = 0; i < 8; i++) begin
                rdata_q[i] <= data_nxt[i];
            end
        end
    end

    assign LSU_rdata_0 = rdata_q[0];
    assign LSU_rdata_1 = rdata_q[1];
    assign LSU_rdata_2 = rdata_q[2];
    assign LSU_rdata_3 = rdata_q[3];
    assign LSU_rdata_4 = rdata_q[4];
    assign LSU_rdata_5 = rdata_q[5];
    assign LSU_rdata_6 = rdata_q[6];
    assign LSU_rdata_7 = rdata_q[7];

endmodule

// File: tb/tb_crossbar_8x8_rdata_return.sv
// Directed bench for the crossbar return path; three instances cover read latencies 1, 2 and 3.
module tb_crossbar_8x8_rdata_return;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  req = 8'h00;
    logic [18:0] bus [8];
    logic [31:0] bg [8];
    logic [31:0] rd1 [8];
    logic [31:0] rd2 [8];
    logic [31:0] rd3 [8];
    logic [7:0]  vld1, vld2, vld3, cf1, cf2, cf3;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    crossbar_8x8_rdata_return #(.A_W(16), .D_W(32), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .LSU_req_vld(req),
        .LSU_addr_bus_0(bus[0]), .LSU_addr_bus_1(bus[1]), .LSU_addr_bus_2(bus[2]), .LSU_addr_bus_3(bus[3]),
        .LSU_addr_bus_4(bus[4]), .LSU_addr_bus_5(bus[5]), .LSU_addr_bus_6(bus[6]), .LSU_addr_bus_7(bus[7]),
        .BG_data_out_0(bg[0]), .BG_data_out_1(bg[1]), .BG_data_out_2(bg[2]), .BG_data_out_3(bg[3]),
        .BG_data_out_4(bg[4]), .BG_data_out_5(bg[5]), .BG_data_out_6(bg[6]), .BG_data_out_7(bg[7]),
        .LSU_rdata_0(rd1[0]), .LSU_rdata_1(rd1[1]), .LSU_rdata_2(rd1[2]), .LSU_rdata_3(rd1[3]),
        .LSU_rdata_4(rd1[4]), .LSU_rdata_5(rd1[5]), .LSU_rdata_6(rd1[6]), .LSU_rdata_7(rd1[7]),
        .LSU_rdata_vld(vld1), .LSU_conflict(cf1));

    crossbar_8x8_rdata_return #(.A_W(16), .D_W(32), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .LSU_req_vld(req),
        .LSU_addr_bus_0(bus[0]), .LSU_addr_bus_1(bus[1]), .LSU_addr_bus_2(bus[2]), .LSU_addr_bus_3(bus[3]),
        .LSU_addr_bus_4(bus[4]), .LSU_addr_bus_5(bus[5]), .LSU_addr_bus_6(bus[6]), .LSU_addr_bus_7(bus[7]),
        .BG_data_out_0(bg[0]), .BG_data_out_1(bg[1]), .BG_data_out_2(bg[2]), .BG_data_out_3(bg[3]),
        .BG_data_out_4(bg[4]), .BG_data_out_5(bg[5]), .BG_data_out_6(bg[6]), .BG_data_out_7(bg[7]),
        .LSU_rdata_0(rd2[0]), .LSU_rdata_1(rd2[1]), .LSU_rdata_2(rd2[2]), .LSU_rdata_3(rd2[3]),
        .LSU_rdata_4(rd2[4]), .LSU_rdata_5(rd2[5]), .LSU_rdata_6(rd2[6]), .LSU_rdata_7(rd2[7]),
        .LSU_rdata_vld(vld2), .LSU_conflict(cf2));

    crossbar_8x8_rdata_return #(.A_W(16), .D_W(32), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .LSU_req_vld(req),
        .LSU_addr_bus_0(bus[0]), .LSU_addr_bus_1(bus[1]), .LSU_addr_bus_2(bus[2]), .LSU_addr_bus_3(bus[3]),
        .LSU_addr_bus_4(bus[4]), .LSU_addr_bus_5(bus[5]), .LSU_addr_bus_6(bus[6]), .LSU_addr_bus_7(bus[7]),
        .BG_data_out_0(bg[0]), .BG_data_out_1(bg[1]), .BG_data_out_2(bg[2]), .BG_data_out_3(bg[3]),
        .BG_data_out_4(bg[4]), .BG_data_out_5(bg[5]), .BG_data_out_6(bg[6]), .BG_data_out_7(bg[7]),
        .LSU_rdata_0(rd3[0]), .LSU_rdata_1(rd3[1]), .LSU_rdata_2(rd3[2]), .LSU_rdata_3(rd3[3]),
        .LSU_rdata_4(rd3[4]), .LSU_rdata_5(rd3[5]), .LSU_rdata_6(rd3[6]), .LSU_rdata_7(rd3[7]),
        .LSU_rdata_vld(vld3), .LSU_conflict(cf3));

    // Inputs change on the falling edge; DUT outputs are sampled there too, half a cycle from the capture edge.
    task automatic set_sel(input int lsu, input int s);
        bus[lsu] = {3'(s), 16'($urandom)};
    endtask

    task automatic randomize_bg();
        for (int b = 0; b < 8; b++) bg[b] = $urandom;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            req = 8'h00;
            randomize_bg();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req = 8'($urandom);
            for (int i = 0; i < 8; i++) set_sel(i, int'($urandom_range(0, 7)));
            randomize_bg();
            #1;
            checks++;
            if (vld1 !== 8'h00 || vld3 !== 8'h00) begin
                errors++;
                $display("FAIL reset_vld: lat1=%h lat3=%h expected 00", vld1, vld3);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rd1[i] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_rdata[%0d]: got %h expected 00000000", i, rd1[i]);
                end
            end
        end
        @(negedge clk);
        req = 8'hFF;
        for (int i = 0; i < 8; i++) set_sel(i, 6);
        #1;
        checks++;
        if (cf1 !== 8'h7F) begin
            errors++;
            $display("FAIL reset_conflict_comb: got %h expected 7f", cf1);
        end
        @(negedge clk);
        req = 8'h00;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midflight();
        idle(4);
        @(negedge clk);
        req = 8'h04;
        set_sel(2, 4);
        @(negedge clk);
        req = 8'h00;
        rst_n = 1'b0;
        for (int b = 0; b < 8; b++) bg[b] = 32'h5A5A_0000 | 32'(b);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (vld2 !== 8'h00 || rd2[2] !== 32'h0) begin
                errors++;
                $display("FAIL midflight_reset cyc%0d: vld=%h rdata2=%h expected 00/00000000", c, vld2, rd2[2]);
            end
        end
    endtask

    task automatic test_single_read();
        idle(4);
        @(negedge clk);
        req = 8'h08;
        set_sel(3, 5);
        #1;
        checks++;
        if (cf1 !== 8'h00) begin
            errors++;
            $display("FAIL single_conflict: got %h expected 00", cf1);
        end
        @(negedge clk);
        req = 8'h00;
        randomize_bg();
        bg[5] = 32'hCAFE0005;
        @(negedge clk);
        #1;
        checks++;
        if (rd1[3] !== 32'hCAFE0005 || vld1 !== 8'h08) begin
            errors++;
            $display("FAIL single_read: rdata3=%h vld=%h expected cafe0005/08", rd1[3], vld1);
        end
    endtask

    task automatic test_conflict();
        idle(4);
        @(negedge clk);
        req = 8'h52;
        set_sel(1, 2);
        set_sel(4, 2);
        set_sel(6, 2);
        #1;
        checks++;
        if (cf1 !== 8'h12) begin
            errors++;
            $display("FAIL conflict_flags: got %h expected 12", cf1);
        end
        @(negedge clk);
        req = 8'h00;
        randomize_bg();
        bg[2] = 32'h2222_2222;
        @(negedge clk);
        #1;
        checks++;
        if (vld1 !== 8'h40 || rd1[6] !== 32'h2222_2222 || rd1[1] !== 32'h0 || rd1[4] !== 32'h0) begin
            errors++;
            $display("FAIL conflict_return: vld=%h r6=%h r1=%h r4=%h expected 40/22222222/0/0",
                     vld1, rd1[6], rd1[1], rd1[4]);
        end
    endtask

    task automatic test_all_one_bg();
        idle(4);
        @(negedge clk);
        req = 8'hFF;
        for (int i = 0; i < 8; i++) set_sel(i, 3);
        #1;
        checks++;
        if (cf1 !== 8'h7F) begin
            errors++;
            $display("FAIL all_one_bg_conflict: got %h expected 7f", cf1);
        end
        @(negedge clk);
        req = 8'h00;
        randomize_bg();
        bg[3] = 32'h3333_0007;
        @(negedge clk);
        #1;
        checks++;
        if (vld1 !== 8'h80 || rd1[7] !== 32'h3333_0007) begin
            errors++;
            $display("FAIL all_one_bg_return: vld=%h r7=%h expected 80/33330007", vld1, rd1[7]);
        end
    endtask

    task automatic test_permutation();
        idle(4);
        @(negedge clk);
        req = 8'hFF;
        for (int i = 0; i < 8; i++) set_sel(i, 7 - i);
        #1;
        checks++;
        if (cf1 !== 8'h00) begin
            errors++;
            $display("FAIL perm_conflict: got %h expected 00", cf1);
        end
        @(negedge clk);
        req = 8'h00;
        for (int b = 0; b < 8; b++) bg[b] = 32'(b) * 32'h1111;
        @(negedge clk);
        #1;
        checks++;
        if (vld1 !== 8'hFF) begin
            errors++;
            $display("FAIL perm_vld: got %h expected ff", vld1);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd1[i] !== 32'(7 - i) * 32'h1111) begin
                errors++;
                $display("FAIL perm_rdata[%0d]: got %h expected %h", i, rd1[i], 32'(7 - i) * 32'h1111);
            end
        end
    endtask

    task automatic test_back_to_back();
        idle(4);
        @(negedge clk);
        req = 8'h20;
        set_sel(5, 1);
        @(negedge clk);
        set_sel(5, 6);
        randomize_bg();
        bg[1] = 32'hB2B0_0001;
        @(negedge clk);
        req = 8'h00;
        randomize_bg();
        bg[6] = 32'hB2B0_0006;
        #1;
        checks++;
        if (vld1 !== 8'h20 || rd1[5] !== 32'hB2B0_0001) begin
            errors++;
            $display("FAIL b2b_first: vld=%h r5=%h expected 20/b2b00001", vld1, rd1[5]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (vld1 !== 8'h20 || rd1[5] !== 32'hB2B0_0006) begin
            errors++;
            $display("FAIL b2b_second: vld=%h r5=%h expected 20/b2b00006", vld1, rd1[5]);
        end
    endtask

    // RD_LAT=3: sel k issued at step k, bank k drives data at step k+3, LSU0 sees it at step k+4.
    task automatic test_pipeline();
        logic [31:0] exp_d;
        logic [7:0]  exp_v;
        idle(5);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            #1;
            if (c >= 4 && c <= 7) begin
                exp_v = 8'h01;
                exp_d = 32'hB000_0000 | (32'(c - 1) << 8) | 32'(c - 4);
            end else begin
                exp_v = 8'h00;
                exp_d = 32'h0;
            end
            checks++;
            if (vld3 !== exp_v || rd3[0] !== exp_d) begin
                errors++;
                $display("FAIL pipeline step%0d: vld=%h r0=%h expected %h/%h", c, vld3, rd3[0], exp_v, exp_d);
            end
            req = (c < 4) ? 8'h01 : 8'h00;
            set_sel(0, c % 8);
            for (int b = 0; b < 8; b++) bg[b] = 32'hB000_0000 | (32'(c) << 8) | 32'(b);
        end
    endtask

    task automatic test_idle();
        idle(3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req = 8'h00;
            for (int i = 0; i < 8; i++) set_sel(i, int'($urandom_range(0, 7)));
            for (int b = 0; b < 8; b++) bg[b] = (c % 2 == 0) ? 32'hFFFF_FFFF : 32'h0F0F_0F0F;
            #1;
            checks++;
            if (vld1 !== 8'h00 || vld2 !== 8'h00 || vld3 !== 8'h00) begin
                errors++;
                $display("FAIL idle_vld cyc%0d: %h %h %h expected 00", c, vld1, vld2, vld3);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rd1[i] !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_rdata[%0d] cyc%0d: got %h expected 00000000", i, c, rd1[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            bus[i] = 19'h0;
            bg[i] = 32'h0;
        end
        test_reset();
        test_reset_midflight();
        test_single_read();
        test_conflict();
        test_all_one_bg();
        test_permutation();
        test_back_to_back();
        test_pipeline();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
